alarm_clock_multi: RTL

- Parametrised successor to the single-alarm clock: a 24-hour HH:MM:SS timekeeper driven by a prescaled system clock, with NUM_ALARMS independently programmable alarm channels.
- Each channel has its own enable, snooze and auto-timeout state machine.
- Unlike the previous generation, the clock keeps running while alarms are programmed, rejects out-of-range loads and wraps the day correctly at 23:59:59.
- Sits between the user-input decoder and the display/buzzer driver.

---
 rtl/alarm_clock_pkg.sv | 40 ++++
 rtl/alarm_channel.sv | 69 ++++++
 rtl/alarm_clock_multi.sv | 112 +++++++++++
 3 files changed

// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared types, limits and time helpers for the multi-alarm clock
package alarm_clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);
    localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZED = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } time_t;

    // m is at most 59, so at most one hour carry can occur
    function automatic time_t add_minutes(time_t t, logic [MIN_W-1:0] m);
        time_t          r;
        logic [MIN_W:0] total;
        r     = t;
        total = {1'b0, t.min} + {1'b0, m};
        if (total > {1'b0, MIN_MAX}) begin
            r.min  = total[MIN_W-1:0] - MIN_W'(60);
            r.hour = (t.hour == HOUR_MAX) ? '0 : t.hour + 1'b1;
        end else begin
            r.min = total[MIN_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: targets, snooze and ring-timeout state machine
module alarm_channel
    import alarm_clock_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  adv,
    input  time_t now,
    input  logic  ld,
    input  logic  ld_en,
    input  time_t ld_target,
    input  logic  stop_alarm,
    input  logic  snooze,
    output logic  ringing
);

    localparam int CW = $clog2(RING_TIMEOUT_S + 1);

    chan_state_e   state, state_n;
    time_t         target, snz_target;
    logic [CW-1:0] ring_cnt;
    logic          hit_primary, hit_snooze, timeout;

    // matches only count on the cycle a fresh second is shown, never after a load
    assign hit_primary = adv && (now == target);
    assign hit_snooze  = adv && (now == snz_target);
    assign timeout     = adv && (ring_cnt == CW'(RING_TIMEOUT_S - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = IDLE;
            ARMED:   if (hit_primary) state_n = RINGING;
            RINGING: begin
                if (stop_alarm)   state_n = ARMED;
                else if (snooze)  state_n = SNOOZED;
                else if (timeout) state_n = ARMED;
            end
            SNOOZED: begin
                if (stop_alarm)                     state_n = ARMED;
                else if (hit_primary || hit_snooze) state_n = RINGING;
            end
            default: state_n = IDLE;
        endcase
        if (ld) state_n = ld_en ? ARMED : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            target     <= '0;
            snz_target <= '0;
            ring_cnt   <= '0;
        end else begin
            state <= state_n;
            if (ld) target <= ld_target;
            if (state == RINGING && state_n == SNOOZED)
                snz_target <= add_minutes(now, MIN_W'(SNOOZE_MIN));
            if (state != RINGING) ring_cnt <= '0;
            else if (adv)         ring_cnt <= ring_cnt + 1'b1;
        end
    end

    assign ringing = (state == RINGING);

endmodule

// File: rtl/alarm_clock_multi.sv
// rtl/alarm_clock_multi.sv - 24-hour timekeeper with NUM_ALARMS programmable alarm channels
module alarm_clock_multi
    import alarm_clock_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 10,
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int IDX_W          = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_time,
    input  logic                  ld_alarm,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic                  alarm_en_in,
    input  logic [SEC_W-1:0]      sec_in,
    input  logic [MIN_W-1:0]      min_in,
    input  logic [HOUR_W-1:0]     hour_in,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    output logic [SEC_W-1:0]      sec,
    output logic [MIN_W-1:0]      min,
    output logic [HOUR_W-1:0]     hour,
    output logic                  sec_tick,
    output logic                  day_tick,
    output logic [NUM_ALARMS-1:0] alarm_vec,
    output logic                  alarm,
    output logic                  load_err
);

    localparam int PW = $clog2(TICKS_PER_SEC);

    logic [PW-1:0] presc;
    logic          load_ok, time_ld, alarm_ld, load_bad, presc_wrap;
    time_t         now, ld_val;

    assign load_ok    = (sec_in <= SEC_MAX) && (min_in <= MIN_MAX) && (hour_in <= HOUR_MAX);
    assign time_ld    = ld_time && load_ok;
    // ld_time takes the cycle; a colliding ld_alarm is silently dropped
    assign alarm_ld   = ld_alarm && !ld_time && load_ok;
    assign load_bad   = (ld_time || ld_alarm) && !load_ok;
    assign presc_wrap = (presc == PW'(TICKS_PER_SEC - 1));

    assign now    = '{hour: hour, min: min, sec: sec};
    assign ld_val = '{hour: hour_in, min: min_in, sec: sec_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc    <= '0;
            sec      <= '0;
            min      <= '0;
            hour     <= '0;
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            load_err <= load_bad;
            if (time_ld) begin
                sec   <= sec_in;
                min   <= min_in;
                hour  <= hour_in;
                presc <= '0;
            end else if (presc_wrap) begin
                presc    <= '0;
                sec_tick <= 1'b1;
                if (sec == SEC_MAX) begin
                    sec <= '0;
                    if (min == MIN_MAX) begin
                        min <= '0;
                        if (hour == HOUR_MAX) begin
                            hour     <= '0;
                            day_tick <= 1'b1;
                        end else begin
                            hour <= hour + 1'b1;
                        end
                    end else begin
                        min <= min + 1'b1;
                    end
                end else begin
                    sec <= sec + 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // sec_tick doubles as the registered advance flag that qualifies matches
    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .SNOOZE_MIN     (SNOOZE_MIN),
            .RING_TIMEOUT_S (RING_TIMEOUT_S)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .adv        (sec_tick),
            .now        (now),
            .ld         (alarm_ld && (alarm_idx == IDX_W'(i))),
            .ld_en      (alarm_en_in),
            .ld_target  (ld_val),
            .stop_alarm (stop_alarm),
            .snooze     (snooze),
            .ringing    (alarm_vec[i])
        );
    end

    assign alarm = |alarm_vec;

endmodule
